// File: rtl/mic_ifu.sv
// mic_ifu -- instruction fetch unit for the MIC datapath.
//
// Prefetches big-endian 32-bit words from memory into a small byte queue
// and presents the head of the queue as MBR1 / MBR2 for the B bus.
// A private byte-granular PC tracks the address of queue byte 0.
//
// Ports
//   clk        system clock, all state on posedge
//   reset      asynchronous, active-low reset
//   pcLoad     PC written from the C bus this cycle (flushes the queue)
//   pcIn       new PC byte address
//   consume1   microinstruction read MBR1, advance 1 byte
//   consume2   microinstruction read MBR2, advance 2 bytes
//   memReq     fetch request level, held until memValid
//   memAddr    word-aligned fetch address, held while memReq is high
//   memRdata   fetched word, byte at addr+0 in [31:24]
//   memValid   one-cycle strobe, memRdata valid
//   mbr1       queue byte 0
//   mbr1Sx     mbr1 sign-extended to 32 bits
//   mbr1Zx     mbr1 zero-extended to 32 bits
//   mbr2Sx     {byte0,byte1} sign-extended to 32 bits
//   mbr1Valid  at least one byte queued
//   mbr2Valid  at least two bytes queued
//   pcOut      byte address of queue byte 0
module mic_ifu #(
   parameter int QUEUE_BYTES = 6,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pcLoad,
   input  logic [31:0]       pcIn,
   input  logic              consume1,
   input  logic              consume2,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   input  logic [31:0]       memRdata,
   input  logic              memValid,
   output logic [7:0]        mbr1,
   output logic [31:0]       mbr1Sx,
   output logic [31:0]       mbr1Zx,
   output logic [31:0]       mbr2Sx,
   output logic              mbr1Valid,
   output logic              mbr2Valid,
   output logic [31:0]       pcOut
);

   localparam int CW = $clog2(QUEUE_BYTES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [7:0]        q     [QUEUE_BYTES];
   logic [7:0]        q_nxt [QUEUE_BYTES];
   logic [7:0]        q_sh  [QUEUE_BYTES];
   logic [CW-1:0]     count, count_nxt, count_c;
   logic [ADDR_W-1:0] imar, imar_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [1:0]        skip, skip_nxt;
   logic [31:0]       pc, pc_nxt;
   logic [1:0]        used;
   logic [2:0]        n_app;
   logic              take;

   function automatic logic [31:0] sx8(input logic signed [7:0] b);
      logic signed [31:0] r;
      r = b;
      return r;
   endfunction

   function automatic logic [31:0] zx8(input logic [7:0] b);
      return {24'h000000, b};
   endfunction

   function automatic logic [31:0] sx16(input logic signed [15:0] h);
      logic signed [31:0] r;
      r = h;
      return r;
   endfunction

   // Bytes consumed this cycle; a consume that the queue cannot satisfy is dropped.
   always_comb begin
      used = 2'd0;
      if (consume2 && (count >= CW'(2)))
         used = 2'd2;
      else if (consume1 && (count >= CW'(1)))
         used = 2'd1;
   end

   assign count_c = count - CW'(used);
   assign n_app   = 3'd4 - {1'b0, skip};
   // Only a response to a live request is appended; a same-cycle pcLoad kills it.
   assign take    = (state == S_WAIT) && memValid && !pcLoad;

   always_comb begin
      for (int i = 0; i < QUEUE_BYTES; i++) begin
         q_sh[i] = 8'h00;
         if (i + int'(used) < QUEUE_BYTES)
            q_sh[i] = q[i + int'(used)];
      end
   end

   always_comb begin
      int idx;
      idx       = 0;
      state_nxt = state;
      addr_nxt  = addr;
      imar_nxt  = imar;
      skip_nxt  = skip;
      pc_nxt    = pc;
      count_nxt = count;
      for (int i = 0; i < QUEUE_BYTES; i++)
         q_nxt[i] = q[i];

      case (state)
         S_IDLE: begin
            // Issue only when a whole word is guaranteed to fit.
            if (!pcLoad && (count <= CW'(QUEUE_BYTES - 4))) begin
               state_nxt = S_WAIT;
               addr_nxt  = imar;
            end
         end
         S_WAIT: begin
            if (memValid)
               state_nxt = S_IDLE;
            else if (pcLoad)
               state_nxt = S_DROP;
         end
         S_DROP: begin
            // The outstanding request must still retire; its data is stale.
            if (memValid)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (pcLoad) begin
         count_nxt = '0;
         pc_nxt    = pcIn;
         imar_nxt  = {pcIn[ADDR_W-1:2], 2'b00};
         skip_nxt  = pcIn[1:0];
      end else begin
         for (int i = 0; i < QUEUE_BYTES; i++)
            q_nxt[i] = q_sh[i];
         count_nxt = count_c;
         pc_nxt    = pc + 32'(used);
         if (take) begin
            // Append after the consume shift; leading bytes before an unaligned
            // PC target are skipped once.
            for (int k = 0; k < 4; k++) begin
               if (k >= int'(skip)) begin
                  idx = int'(count_c) + k - int'(skip);
                  if (idx < QUEUE_BYTES)
                     q_nxt[idx] = memRdata[31 - 8*k -: 8];
               end
            end
            count_nxt = count_c + CW'(n_app);
            skip_nxt  = 2'd0;
            imar_nxt  = imar + ADDR_W'(4);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         addr  <= '0;
         imar  <= '0;
         skip  <= 2'd0;
         pc    <= 32'h0;
         count <= '0;
         for (int i = 0; i < QUEUE_BYTES; i++)
            q[i] <= 8'h00;
      end else begin
         state <= state_nxt;
         addr  <= addr_nxt;
         imar  <= imar_nxt;
         skip  <= skip_nxt;
         pc    <= pc_nxt;
         count <= count_nxt;
         for (int i = 0; i < QUEUE_BYTES; i++)
            q[i] <= q_nxt[i];
      end
   end

   assign memReq    = (state != S_IDLE);
   assign memAddr   = addr;
   assign mbr1      = q[0];
   assign mbr1Sx    = sx8(q[0]);
   assign mbr1Zx    = zx8(q[0]);
   assign mbr2Sx    = sx16({q[0], q[1]});
   assign mbr1Valid = (count >= CW'(1));
   assign mbr2Valid = (count >= CW'(2));
   assign pcOut     = pc;

endmodule

// File: tb/tb_mic_ifu.sv
// tb_mic_ifu -- directed, table-driven bench for mic_ifu.
// Each table row holds the outputs expected at the start of a cycle and the
// inputs applied during that cycle; memory responses are part of the rows.
module tb_mic_ifu;

   logic        clk = 1'b0;
   logic        reset;
   logic        pcLoad;
   logic [31:0] pcIn;
   logic        consume1;
   logic        consume2;
   logic        memReq;
   logic [31:0] memAddr;
   logic [31:0] memRdata;
   logic        memValid;
   logic [7:0]  mbr1;
   logic [31:0] mbr1Sx;
   logic [31:0] mbr1Zx;
   logic [31:0] mbr2Sx;
   logic        mbr1Valid;
   logic        mbr2Valid;
   logic [31:0] pcOut;

   int nvec = 0;
   int nerr = 0;

   mic_ifu #(.QUEUE_BYTES(6), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .pcLoad(pcLoad), .pcIn(pcIn),
      .consume1(consume1), .consume2(consume2),
      .memReq(memReq), .memAddr(memAddr), .memRdata(memRdata), .memValid(memValid),
      .mbr1(mbr1), .mbr1Sx(mbr1Sx), .mbr1Zx(mbr1Zx), .mbr2Sx(mbr2Sx),
      .mbr1Valid(mbr1Valid), .mbr2Valid(mbr2Valid), .pcOut(pcOut)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic [31:0] pc_in;
      logic        c1;
      logic        c2;
      logic        mv;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v1;
      logic        e_v2;
      logic [7:0]  e_m1;
      logic [31:0] e_m2;
      logic [31:0] e_pc;
   } vec_t;

   localparam int NROWS = 38;
   vec_t tbl [NROWS];

   function automatic vec_t mk(input logic ld, input logic [31:0] pc_in,
                               input logic c1, input logic c2, input logic mv,
                               input logic [31:0] rd, input logic e_req,
                               input logic [31:0] e_addr, input logic e_v1,
                               input logic e_v2, input logic [7:0] e_m1,
                               input logic [31:0] e_m2, input logic [31:0] e_pc);
      vec_t v;
      v.ld = ld; v.pc_in = pc_in; v.c1 = c1; v.c2 = c2; v.mv = mv; v.rd = rd;
      v.e_req = e_req; v.e_addr = e_addr; v.e_v1 = e_v1; v.e_v2 = e_v2;
      v.e_m1 = e_m1; v.e_m2 = e_m2; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic chk(input string nm, input int row, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s row %0d: got %h expected %h", nm, row, got, exp);
      end
   endtask

   task automatic check_row(input int i);
      vec_t t;
      t = tbl[i];
      chk("memReq", i, 32'(memReq), 32'(t.e_req));
      if (t.e_req)
         chk("memAddr", i, memAddr, t.e_addr);
      chk("mbr1Valid", i, 32'(mbr1Valid), 32'(t.e_v1));
      chk("mbr2Valid", i, 32'(mbr2Valid), 32'(t.e_v2));
      chk("pcOut", i, pcOut, t.e_pc);
      if (t.e_v1) begin
         chk("mbr1", i, 32'(mbr1), 32'(t.e_m1));
         chk("mbr1Sx", i, mbr1Sx, {{24{t.e_m1[7]}}, t.e_m1});
         chk("mbr1Zx", i, mbr1Zx, {24'h000000, t.e_m1});
      end
      if (t.e_v2)
         chk("mbr2Sx", i, mbr2Sx, t.e_m2);
   endtask

   task automatic idle_inputs();
      pcLoad = 1'b0; pcIn = 32'h0; consume1 = 1'b0; consume2 = 1'b0;
      memValid = 1'b0; memRdata = 32'h0;
   endtask

   initial begin
      //                ld pcIn          c1 c2 mv rdata         req addr         v1 v2 mbr1   mbr2Sx        pcOut
      tbl[0]  = mk(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 8'h00, 32'h0,        32'h0);
      tbl[1]  = mk(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 8'h00, 32'h0,        32'h0);
      tbl[2]  = mk(0, 32'h0,        0, 0, 1, 32'h10203040, 1, 32'h0,        0, 0, 8'h00, 32'h0,        32'h0);
      tbl[3]  = mk(0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h10, 32'h00001020, 32'h0);
      tbl[4]  = mk(0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h20, 32'h00002030, 32'h1);
      tbl[5]  = mk(0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h30, 32'h00003040, 32'h2);
      tbl[6]  = mk(0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h4,        1, 0, 8'h40, 32'h0,        32'h3);
      tbl[7]  = mk(0, 32'h0,        0, 0, 1, 32'h50607080, 1, 32'h4,        1, 0, 8'h40, 32'h0,        32'h3);
      tbl[8]  = mk(0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 8'h40, 32'h00004050, 32'h3);
      tbl[9]  = mk(0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h60, 32'h00006070, 32'h5);
      tbl[10] = mk(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h70, 32'h00007080, 32'h6);
      tbl[11] = mk(0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h8,        1, 1, 8'h70, 32'h00007080, 32'h6);
      tbl[12] = mk(1, 32'h6,        0, 0, 0, 32'h0,        1, 32'h8,        1, 0, 8'h80, 32'h0,        32'h7);
      tbl[13] = mk(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h8,        0, 0, 8'h00, 32'h0,        32'h6);
      tbl[14] = mk(0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 1, 32'h8,        0, 0, 8'h00, 32'h0,        32'h6);
      tbl[15] = mk(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 8'h00, 32'h0,        32'h6);
      tbl[16] = mk(0, 32'h0,        0, 0, 1, 32'h50607080, 1, 32'h4,        0, 0, 8'h00, 32'h0,        32'h6);
      tbl[17] = mk(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h70, 32'h00007080, 32'h6);
      tbl[18] = mk(0, 32'h0,        0, 0, 1, 32'h11223344, 1, 32'h8,        1, 1, 8'h70, 32'h00007080, 32'h6);
      tbl[19] = mk(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h70, 32'h00007080, 32'h6);
      tbl[20] = mk(0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 8'h70, 32'h00007080, 32'h6);
      tbl[21] = mk(0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 8'h11, 32'h00001122, 32'h8);
      tbl[22] = mk(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h33, 32'h00003344, 32'hA);
      tbl[23] = mk(0, 32'h0,        0, 0, 1, 32'h55667788, 1, 32'hC,        1, 1, 8'h33, 32'h00003344, 32'hA);
      tbl[24] = mk(0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h33, 32'h00003344, 32'hA);
      tbl[25] = mk(0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h44, 32'h00004455, 32'hB);
      tbl[26] = mk(0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h55, 32'h00005566, 32'hC);
      tbl[27] = mk(0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,        1, 1, 8'h66, 32'h00006677, 32'hD);
      tbl[28] = mk(0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 8'h88, 32'h0,        32'hF);
      tbl[29] = mk(0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h10,       1, 0, 8'h88, 32'h0,        32'hF);
      tbl[30] = mk(0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h10,       0, 0, 8'h00, 32'h0,        32'h10);
      tbl[31] = mk(0, 32'h0,        0, 0, 1, 32'h99AABBCC, 1, 32'h10,       0, 0, 8'h00, 32'h0,        32'h10);
      tbl[32] = mk(0, 32'h0,        0, 0, 1, 32'h12345678, 0, 32'h0,        1, 1, 8'h99, 32'hFFFF99AA, 32'h10);
      tbl[33] = mk(1, 32'hFFFFFFFF, 1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 8'h99, 32'hFFFF99AA, 32'h10);
      tbl[34] = mk(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 8'h00, 32'h0,        32'hFFFFFFFF);
      tbl[35] = mk(0, 32'h0,        0, 0, 1, 32'hA1B2C3D4, 1, 32'hFFFFFFFC, 0, 0, 8'h00, 32'h0,        32'hFFFFFFFF);
      tbl[36] = mk(0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 8'hD4, 32'h0,        32'hFFFFFFFF);
      tbl[37] = mk(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 8'h00, 32'h0,        32'h0);

      // Reset state
      reset = 1'b0;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      chk("rst_memReq", -1, 32'(memReq), 32'h0);
      chk("rst_pcOut", -1, pcOut, 32'h0);
      chk("rst_mbr1", -1, 32'(mbr1), 32'h0);
      chk("rst_mbr1Sx", -1, mbr1Sx, 32'h0);
      chk("rst_mbr2Sx", -1, mbr2Sx, 32'h0);
      chk("rst_mbr1Valid", -1, 32'(mbr1Valid), 32'h0);
      chk("rst_mbr2Valid", -1, 32'(mbr2Valid), 32'h0);
      reset = 1'b1;

      // Table: check the cycle's starting outputs, then drive its inputs
      for (int i = 0; i < NROWS; i++) begin
         check_row(i);
         pcLoad   = tbl[i].ld;
         pcIn     = tbl[i].pc_in;
         consume1 = tbl[i].c1;
         consume2 = tbl[i].c2;
         memValid = tbl[i].mv;
         memRdata = tbl[i].rd;
         @(negedge clk);
      end
      idle_inputs();

      // Reset while a request to 0 is outstanding: memReq must drop at once
      chk("pre_rst_memReq", 100, 32'(memReq), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_memReq", 100, 32'(memReq), 32'h0);
      chk("async_rst_pcOut", 100, pcOut, 32'h0);
      chk("async_rst_mbr1Valid", 100, 32'(mbr1Valid), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Stale response arrives right after release, while idle
      memValid = 1'b1;
      memRdata = 32'hBAD0BAD0;
      @(negedge clk);
      idle_inputs();
      chk("fresh_memReq", 101, 32'(memReq), 32'h1);
      chk("fresh_memAddr", 101, memAddr, 32'h0);
      chk("stale_ignored", 101, 32'(mbr1Valid), 32'h0);

      // Fresh fetch completes
      memValid = 1'b1;
      memRdata = 32'h10203040;
      @(negedge clk);
      idle_inputs();
      chk("fresh_done_memReq", 102, 32'(memReq), 32'h0);
      chk("fresh_mbr1", 102, 32'(mbr1), 32'h10);
      chk("fresh_mbr2Sx", 102, mbr2Sx, 32'h00001020);
      chk("fresh_mbr2Valid", 102, 32'(mbr2Valid), 32'h1);
      chk("fresh_pcOut", 102, pcOut, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mic_ifu.md
Name: mic_ifu

Overview:
- Instruction fetch unit for the MIC datapath. Sits directly downstream of the PC register.
- Takes the PC value written from the C bus, fetches 32-bit words from main memory ahead of use, and queues the bytes.
- Presents the next opcode/operand bytes as MBR1 (8-bit) and MBR2 (16-bit) for the B bus.
- Keeps its own byte-granular program counter, which advances as the microprogram consumes bytes.

Parameters:
- QUEUE_BYTES, 6, byte capacity of the fetch queue; must be at least 6.
- ADDR_W, 32, memory byte-address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- pcLoad  in  1  PC written this cycle (C bus write to PC).
- pcIn  in  32  new PC byte address.
- consume1  in  1  microinstruction read MBR1; advance 1 byte.
- consume2  in  1  microinstruction read MBR2; advance 2 bytes.
- memReq  out  1  fetch request level.
- memAddr  out  ADDR_W  word-aligned byte address of the fetch; bits [1:0] always 00.
- memRdata  in  32  fetched word, big-endian (byte at addr+0 in [31:24]).
- memValid  in  1  one-cycle strobe: memRdata valid for the outstanding request.
- mbr1  out  8  queue byte 0.
- mbr1Sx  out  32  mbr1 sign-extended.
- mbr1Zx  out  32  mbr1 zero-extended.
- mbr2Sx  out  32  {byte0,byte1} sign-extended to 32 bits.
- mbr1Valid  out  1  queue count >= 1.
- mbr2Valid  out  1  queue count >= 2.
- pcOut  out  32  byte address of queue byte 0.

Behaviour:
- Reset (async, reset=0):
  - queue count=0, all queue bytes 0, fetch address register imar=0, skip=0, state=IDLE.
  - Outputs: memReq=0, pcOut=0, mbr*=0, valids=0.
- State machine, one request outstanding at most:
  - IDLE -> WAIT when count <= QUEUE_BYTES-4 and no pcLoad this cycle. memReq=1 and memAddr=imar from the next cycle on.
  - In WAIT, memReq and memAddr are held stable until memValid.
  - WAIT + memValid: append the bytes, imar += 4, memReq=0 next cycle, go to IDLE. A new request can issue one cycle later at the earliest.
  - WAIT + pcLoad: go to DROP. memReq stays 1 until memValid. In DROP, memValid data is discarded, then go to IDLE.
  - memValid in IDLE is ignored.
- pcLoad (highest priority, beats consume and append in the same cycle):
  - Queue flushed (count=0); pcOut=pcIn.
  - imar = {pcIn[31:2],2'b00}; skip = pcIn[1:0].
  - The first appended word after a flush drops its first `skip` bytes (appends 4-skip bytes), then skip=0.
- Append: bytes are appended in order [31:24],[23:16],[15:8],[7:0] at positions count.. after any same-cycle consume shift.
- Consume:
  - consume2 with count >= 2: shift queue by 2, pcOut += 2.
  - consume1 with count >= 1: shift by 1, pcOut += 1.
  - Both asserted: consume2 wins.
  - Consume with insufficient bytes: ignored; queue and pcOut unchanged.
  - A consume and an append in the same cycle: count_next = count - consumed + appended. The capacity check at issue guarantees no overflow.
- pcOut wraps modulo 2^32; imar wraps modulo 2^32.
- mbr outputs reflect registered queue state, with no combinational path from memRdata. The byte returned by memory is visible at mbr1 one cycle after memValid.
- mbr values are undefined-but-stable when the corresponding valid is 0. The microsequencer must stall on valid=0.

Test Plan:
- Release reset with memory latency 2 and words 0x10203040, 0x50607080 at addresses 0 and 4 -> memReq rises the cycle after release with memAddr=0. mbr1=0x10 and mbr2Sx=0x00001020 one cycle after the first memValid. A second request to 4 follows.
- Consume1 x3, then consume2 -> pcOut steps 1,2,3,5. mbr1 shows 0x20, 0x30, 0x40 in turn. After consume2, mbr1=0x60 (pcOut=5). mbr1Sx for 0x80 = 0xFFFFFF80, mbr1Zx = 0x00000080.
- pcLoad pcIn=0x00000006 while a request to 8 is outstanding -> that response is dropped. The next fetch is at memAddr=4; only 0x70, 0x80 are queued; pcOut=6, mbr1=0x70.
- Fill the queue with no consumes -> no request issued while count > 2. Consume2 brings count to 2, and a request issues the next cycle.
- Consume2 at count=1, and consume1 at count=0 -> ignored; pcOut and queue unchanged. Consume1+consume2 together at count=3 -> advance 2.
- Assert reset mid-WAIT -> memReq=0 immediately. A stale memValid after release is ignored. A fresh fetch at address 0 completes correctly.
